// File: rtl/imu_emu_pkg.sv
// Shared constants, register addresses and FSM state type for the IMU SPI responder.
package imu_emu_pkg;

  localparam logic [6:0] ADDR_WHO_AM_I   = 7'h0F;
  localparam logic [6:0] ADDR_CTRL_FIRST = 7'h10;
  localparam logic [6:0] ADDR_CTRL_LAST  = 7'h19;
  localparam logic [6:0] ADDR_CTRL3_C    = 7'h12;
  localparam logic [6:0] ADDR_STATUS     = 7'h1E;
  localparam logic [6:0] ADDR_OUTX_L_XL  = 7'h28;
  localparam logic [6:0] ADDR_OUTX_H_XL  = 7'h29;
  localparam logic [6:0] ADDR_OUTY_L_XL  = 7'h2A;
  localparam logic [6:0] ADDR_OUTY_H_XL  = 7'h2B;
  localparam logic [6:0] ADDR_OUTZ_L_XL  = 7'h2C;
  localparam logic [6:0] ADDR_OUTZ_H_XL  = 7'h2D;

  localparam int unsigned NUM_CTRL      = 10;
  localparam int unsigned CTRL3_C_IDX   = 2;
  localparam logic [7:0]  CTRL3_C_RESET = 8'h04;
  localparam int unsigned IF_INC_BIT    = 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    READ,
    WRITE
  } spi_rsp_state_t;

  function automatic logic is_ctrl_addr(input logic [6:0] addr);
    return (addr >= ADDR_CTRL_FIRST) && (addr <= ADDR_CTRL_LAST);
  endfunction

  function automatic logic is_accel_addr(input logic [6:0] addr);
    return (addr >= ADDR_OUTX_L_XL) && (addr <= ADDR_OUTZ_H_XL);
  endfunction

endpackage

// File: rtl/imu_spi_responder_if.sv
// SPI bus between the IMU master and the responder (mode 3, active-low chip select).
interface imu_spi_responder_if;
  logic SPC;
  logic CS;
  logic SDI;
  logic SDO;
  logic sdo_oe;

  modport master (
    output SPC,
    output CS,
    output SDI,
    input  SDO,
    input  sdo_oe
  );

  modport slave (
    input  SPC,
    input  CS,
    input  SDI,
    output SDO,
    output sdo_oe
  );
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with one-clk rise/fall pulses on the synchronized level.
module spi_edge_sync #(
  parameter int unsigned Stages   = 2,
  parameter bit          ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign level = sync_q[Stages-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/imu_spi_responder.sv
// SPI mode-3 slave emulating the accelerometer register interface: reads with burst
// auto-increment, control-register writes, and block-data-update of accel samples.
module imu_spi_responder
  import imu_emu_pkg::*;
#(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h69,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  imu_spi_responder_if.slave  spi,
  input  logic [15:0]         accel_x,
  input  logic [15:0]         accel_y,
  input  logic [15:0]         accel_z,
  input  logic                sample_valid,
  output logic                ctrl_wr_valid,
  output logic [6:0]          ctrl_wr_addr,
  output logic [7:0]          ctrl_wr_data,
  output logic                busy
);

  logic spc_rise, spc_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic sdi_s;

  spi_edge_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_spc_sync (
    .clk  (clk),
    .reset(reset),
    .d    (spi.SPC),
    .rise (spc_rise),
    .fall (spc_fall)
  );

  // CS chain resets low so a bus held low across reset yields no fall and no "seen high".
  spi_edge_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_cs_sync (
    .clk  (clk),
    .reset(reset),
    .d    (spi.CS),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) sdi_sync_q <= '0;
    else       sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi.SDI};
  end
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  spi_rsp_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [6:0]  addr_q, addr_d;
  logic [6:0]  tx_q, tx_d;
  logic        sdo_q, sdo_d;
  logic        acc_rd_q, acc_rd_d;
  logic        cs_seen_q, cs_seen_d;
  logic [7:0]  ctrl_q [NUM_CTRL];
  logic [7:0]  ctrl_d [NUM_CTRL];
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [15:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic        pend_v_q, pend_v_d;
  logic        xlda_q, xlda_d;

  logic [7:0] rd_byte;
  logic [7:0] rx_byte;
  logic       if_inc;
  logic [6:0] addr_next;
  logic       end_txn;

  assign busy     = (state_q != IDLE);
  assign end_txn  = busy && cs_rise;
  assign rx_byte  = {shreg_q, sdi_s};
  assign if_inc   = ctrl_q[CTRL3_C_IDX][IF_INC_BIT];
  assign addr_next = if_inc ? addr_q + 7'd1 : addr_q;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      ADDR_WHO_AM_I:  rd_byte = WHO_AM_I_VAL;
      ADDR_STATUS:    rd_byte = {7'b0, xlda_q};
      ADDR_OUTX_L_XL: rd_byte = ax_q[7:0];
      ADDR_OUTX_H_XL: rd_byte = ax_q[15:8];
      ADDR_OUTY_L_XL: rd_byte = ay_q[7:0];
      ADDR_OUTY_H_XL: rd_byte = ay_q[15:8];
      ADDR_OUTZ_L_XL: rd_byte = az_q[7:0];
      ADDR_OUTZ_H_XL: rd_byte = az_q[15:8];
      default: begin
        if (is_ctrl_addr(addr_q)) rd_byte = ctrl_q[addr_q[3:0]];
      end
    endcase
  end

  // Bus FSM: rising edges shift command/write data, falling edges drive read data.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    sdo_d      = sdo_q;
    acc_rd_d   = acc_rd_q;
    cs_seen_d  = cs_seen_q | cs_rise;
    ctrl_d     = ctrl_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall && cs_seen_q) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          acc_rd_d  = 1'b0;
        end
      end
      CMD: begin
        if (spc_rise) begin
          shreg_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d  = rx_byte[6:0];
            state_d = rx_byte[7] ? READ : WRITE;
          end
        end
      end
      READ: begin
        if (spc_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sdo_d = rd_byte[7];
            tx_d  = rd_byte[6:0];
          end else begin
            sdo_d = tx_q[6];
            tx_d  = {tx_q[5:0], 1'b0};
          end
        end
        // The master samples bit 0 on the 8th rise; only then is the byte consumed.
        if (spc_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = addr_next;
            if (is_accel_addr(addr_q)) acc_rd_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (spc_rise) begin
          shreg_d   = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (is_ctrl_addr(addr_q)) begin
              ctrl_d[addr_q[3:0]] = rx_byte;
              wr_valid_d          = 1'b1;
              wr_addr_d           = addr_q;
              wr_data_d           = rx_byte;
            end
            addr_d = addr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_txn) state_d = IDLE;
    if (state_d != READ) sdo_d = 1'b1;
  end

  // Samples arriving mid-transaction are parked until CS rises so a burst never mixes samples.
  always_comb begin
    ax_d     = ax_q;
    ay_d     = ay_q;
    az_d     = az_q;
    px_d     = px_q;
    py_d     = py_q;
    pz_d     = pz_q;
    pend_v_d = pend_v_q;
    xlda_d   = xlda_q;

    if (sample_valid && !busy) begin
      ax_d   = accel_x;
      ay_d   = accel_y;
      az_d   = accel_z;
      xlda_d = 1'b1;
    end else if (sample_valid) begin
      px_d     = accel_x;
      py_d     = accel_y;
      pz_d     = accel_z;
      pend_v_d = 1'b1;
    end

    if (end_txn) begin
      if (acc_rd_q) xlda_d = 1'b0;
      if (sample_valid) begin
        ax_d     = accel_x;
        ay_d     = accel_y;
        az_d     = accel_z;
        xlda_d   = 1'b1;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        ax_d     = px_q;
        ay_d     = py_q;
        az_d     = pz_q;
        xlda_d   = 1'b1;
        pend_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      sdo_q      <= 1'b1;
      acc_rd_q   <= 1'b0;
      cs_seen_q  <= 1'b0;
      ctrl_q     <= '{default: 8'h00};
      ctrl_q[CTRL3_C_IDX] <= CTRL3_C_RESET;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      az_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      pz_q       <= '0;
      pend_v_q   <= 1'b0;
      xlda_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      sdo_q      <= sdo_d;
      acc_rd_q   <= acc_rd_d;
      cs_seen_q  <= cs_seen_d;
      ctrl_q     <= ctrl_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      az_q       <= az_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pz_q       <= pz_d;
      pend_v_q   <= pend_v_d;
      xlda_q     <= xlda_d;
    end
  end

  assign spi.SDO       = sdo_q;
  assign spi.sdo_oe    = (state_q == READ);
  assign ctrl_wr_valid = wr_valid_q;
  assign ctrl_wr_addr  = wr_addr_q;
  assign ctrl_wr_data  = wr_data_q;

endmodule

// File: doc/imu_spi_responder.md
Name: imu_spi_responder

Overview:
- Synthesizable SPI-slave model of the accelerometer interface: the peripheral end of the bus the IMU master drives.
- Used in closed-loop benches and in the FPGA self-test build, in place of the real sensor.
- Decodes SPI mode-3 transactions and serves register reads, including auto-incrementing burst reads of accel X/Y/Z, from a small register map.
- Accepts writes to control registers and publishes them on a side port.

Parameters:
- WHO_AM_I_VAL, 8'h69, value returned at address 0x0F.
- SYNC_STAGES, 2, synchronizer depth on SPC/CS/SDI. Must be ≥2.

Ports:
- clk  input  1  system clock; must be ≥10× SPC frequency.
- reset  input  1  synchronous, active-high reset.
- SPC  input  1  SPI clock from master, idles high (mode 3).
- CS  input  1  chip select, active low.
- SDI  input  1  master-out data.
- SDO  output  1  slave-out data.
- sdo_oe  output  1  1 while SDO is driven (read data phase only).
- accel_x, accel_y, accel_z  input  16 each  new sample values, two's complement.
- sample_valid  input  1  one-clk strobe; accel_* valid this cycle.
- ctrl_wr_valid  output  1  one-clk pulse per accepted register write.
- ctrl_wr_addr  output  7  address of that write.
- ctrl_wr_data  output  8  data of that write.
- busy  output  1  1 while a transaction is in progress (CS low, armed).

Behaviour:
- Reset values: SDO=1, sdo_oe=0, ctrl_wr_valid=0, ctrl_wr_addr=0, ctrl_wr_data=0, busy=0. Control regs 0x10–0x19 reset to 0x00, except CTRL3_C (0x12), which resets to 0x04 (IF_INC=1). Accel regs reset to 0. STATUS.XLDA resets to 0.
- Input sync: SPC, CS and SDI each pass through SYNC_STAGES flops. Edge detect on synced SPC and CS gives one-clk rise/fall pulses.
- FSM states:
  - IDLE to CMD: on CS fall, but only if CS has been seen high since reset. After a mid-transaction reset, the block ignores the bus until CS rises.
  - CMD: shift SDI MSB-first on SPC rising edges, 8 bits. bit7=1 means read, bits[6:0] are the address. After the 8th bit, go to READ or WRITE.
  - READ: on each SPC falling edge, drive the next bit, MSB first. The first falling edge after the command loads byte(addr) and drives bit7. After 8 bits, addr increments if IF_INC=1 (else holds), wrapping 0x7F→0x00, and the next byte loads on the following falling edge. sdo_oe=1 in READ.
  - WRITE: shift SDI on rising edges. After each 8th bit:
    - if addr is in 0x10–0x19, store the byte and pulse ctrl_wr_valid with addr/data on the next clk;
    - otherwise discard silently, with no pulse.
    - Then addr increments per IF_INC.
  - Any state: a CS rise returns to IDLE next clk. A partial byte is discarded (no write), and SDO=1, sdo_oe=0.
- Register map (read):
  - 0x0F = WHO_AM_I_VAL.
  - 0x10–0x19 = control regs.
  - 0x1E STATUS = {7'b0, XLDA}.
  - 0x28/29 = accel_x L/H, 0x2A/2B = accel_y L/H, 0x2C/2D = accel_z L/H.
  - All other addresses read 0x00. Writes to read-only addresses are ignored.
- Sample update (block-data-update semantics):
  - sample_valid while busy=0: accel regs update next clk and XLDA is set.
  - sample_valid while busy=1: the sample is held in a pending buffer and applied on the clk after CS rises. A newer pending sample overwrites an older one.
  - A burst read therefore never mixes two samples.
- XLDA clears at CS rise if any byte in 0x28–0x2D was fully shifted out during that transaction. If a pending sample is applied at the same rise, the set wins and XLDA=1.
- Latency: SDO changes within SYNC_STAGES+2 clk of the SPC falling edge. Write pulse appears SYNC_STAGES+2 clk after the 8th data rising edge.
- busy=1 from the clk after CS fall is detected (armed) until the clk after CS rise.

Decomposition:
- Package imu_emu_pkg holds:
  - address constants (ADDR_WHO_AM_I, ADDR_CTRL_FIRST/LAST, ADDR_CTRL3_C, ADDR_STATUS, ADDR_OUTX_L_XL through ADDR_OUTZ_H_XL);
  - the CTRL3_C reset value and IF_INC bit index;
  - the FSM state enum spi_rsp_state_t {IDLE, CMD, READ, WRITE}.
- Sub-module spi_edge_sync: parameterized synchronizer plus rise/fall pulse generator, instantiated for SPC and CS. SDI uses sync only.

Test Plan:
- Read 0x0F (cmd 0x8F) at SPC=1 MHz, clk=25 MHz -> SDO byte 0x69; sdo_oe=1 only in the data phase; no ctrl_wr_valid.
- sample_valid with x=0x1234, y=0xFFFE, z=0x8000, then a 6-byte burst from 0x28 -> 34 12 FE FF 00 80; STATUS read afterward in a new transaction -> 0x00.
- Write 0x00 to CTRL3_C (0x12), then burst-read 2 bytes at 0x28 -> same byte twice. Write 0x12 alone -> one pulse with addr=0x12, data=0x00.
- sample_valid (x=0x0001) mid-burst after 0x28 is already read -> remaining bytes from the old sample; accel_x=0x0001 visible only after CS rise; XLDA=1.
- CS rises after 5 bits of a write to 0x10 -> no pulse, reg 0x10 unchanged. Burst read from 0x7F -> 0x00, then 0x7F→0x00 wrap, returning byte(0x00)=0x00.
- Reset asserted mid-read with CS held low -> outputs at reset values. Further SPC edges ignored until CS high then low; the next 0x8F read returns 0x69.
